// File: rtl/lane_vrf_write_port.sv
// Lane-side VRF write port: buffers write requests in a small FIFO and commits them
// into a 128x32 byte-enabled array that shares its single port with a read path.
module lane_vrf_write_port #(
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vrfWriteRequest_valid,
  output logic        vrfWriteRequest_ready,
  input  logic [4:0]  vrfWriteRequest_bits_vd,
  input  logic [1:0]  vrfWriteRequest_bits_offset,
  input  logic [3:0]  vrfWriteRequest_bits_mask,
  input  logic [31:0] vrfWriteRequest_bits_data,
  input  logic        vrfWriteRequest_bits_last,
  input  logic [2:0]  vrfWriteRequest_bits_instructionIndex,
  input  logic        readRequest_valid,
  output logic        readRequest_ready,
  input  logic [4:0]  readRequest_bits_vs,
  input  logic [1:0]  readRequest_bits_offset,
  output logic        readResult_valid,
  output logic [31:0] readResult_data,
  output logic        writeDone_valid,
  output logic [2:0]  writeDone_bits_instructionIndex,
  output logic [7:0]  instructionActive
);

  localparam int unsigned PtrW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned StallW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned Words  = 128;

  typedef struct packed {
    logic [4:0]  vd;
    logic [1:0]  offset;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
    logic [2:0]  instructionIndex;
  } wrEntry_t;

  wrEntry_t          buffer [BUF_DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [CntW-1:0]   count;
  logic [StallW-1:0] stallCount;
  logic [31:0]       vrf [Words];

  logic     full;
  logic     empty;
  logic     push;
  logic     forceWrite;
  logic     readGrant;
  logic     commit;
  wrEntry_t head;
  logic [6:0] commitAddr;
  logic [6:0] readAddr;
  logic [PtrW-1:0] slotOff;

  assign full       = (count == CntW'(BUF_DEPTH));
  assign empty      = (count == '0);
  assign push       = vrfWriteRequest_valid & ~full;
  assign forceWrite = (stallCount == StallW'(STARVE_LIMIT)) & ~empty;
  assign readGrant  = readRequest_valid & ~forceWrite;
  assign commit     = ~empty & ~readGrant;
  assign head       = buffer[rdPtr];
  assign commitAddr = {head.vd, head.offset};
  assign readAddr   = {readRequest_bits_vs, readRequest_bits_offset};

  assign vrfWriteRequest_ready = ~full;
  assign readRequest_ready     = ~forceWrite;

  // FIFO bookkeeping and read-starvation counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      stallCount <= '0;
    end else begin
      if (push)   wrPtr <= wrPtr + PtrW'(1);
      if (commit) rdPtr <= rdPtr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(commit);
      if (empty || commit) stallCount <= '0;
      else if (readGrant)  stallCount <= stallCount + StallW'(1);
    end
  end

  // Payload storage needs no reset: validity comes from the pointers
  always_ff @(posedge clock) begin
    if (push) begin
      buffer[wrPtr] <= '{vd: vrfWriteRequest_bits_vd,
                         offset: vrfWriteRequest_bits_offset,
                         mask: vrfWriteRequest_bits_mask,
                         data: vrfWriteRequest_bits_data,
                         last: vrfWriteRequest_bits_last,
                         instructionIndex: vrfWriteRequest_bits_instructionIndex};
    end
  end

  // Register-file array with byte-enabled commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < int'(Words); w++) vrf[w] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (head.mask[b]) vrf[commitAddr][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  // Registered read result and completion pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readResult_valid                <= 1'b0;
      readResult_data                 <= '0;
      writeDone_valid                 <= 1'b0;
      writeDone_bits_instructionIndex <= '0;
    end else begin
      readResult_valid <= readGrant;
      if (readGrant) readResult_data <= vrf[readAddr];
      writeDone_valid <= commit & head.last;
      if (commit & head.last) writeDone_bits_instructionIndex <= head.instructionIndex;
    end
  end

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    instructionActive = '0;
    slotOff           = '0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      slotOff = PtrW'(i) - rdPtr;
      if (CntW'(slotOff) < count) instructionActive[buffer[i].instructionIndex] = 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_vrf_write_port.sv
// Directed bench for lane_vrf_write_port with hand-computed expected values.
module tb_lane_vrf_write_port;

  logic        clock;
  logic        reset;
  logic        vrfWriteRequest_valid;
  logic        vrfWriteRequest_ready;
  logic [4:0]  vrfWriteRequest_bits_vd;
  logic [1:0]  vrfWriteRequest_bits_offset;
  logic [3:0]  vrfWriteRequest_bits_mask;
  logic [31:0] vrfWriteRequest_bits_data;
  logic        vrfWriteRequest_bits_last;
  logic [2:0]  vrfWriteRequest_bits_instructionIndex;
  logic        readRequest_valid;
  logic        readRequest_ready;
  logic [4:0]  readRequest_bits_vs;
  logic [1:0]  readRequest_bits_offset;
  logic        readResult_valid;
  logic [31:0] readResult_data;
  logic        writeDone_valid;
  logic [2:0]  writeDone_bits_instructionIndex;
  logic [7:0]  instructionActive;

  int nChecks = 0;
  int nPass   = 0;

  lane_vrf_write_port #(.BUF_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clock(clock),
    .reset(reset),
    .vrfWriteRequest_valid(vrfWriteRequest_valid),
    .vrfWriteRequest_ready(vrfWriteRequest_ready),
    .vrfWriteRequest_bits_vd(vrfWriteRequest_bits_vd),
    .vrfWriteRequest_bits_offset(vrfWriteRequest_bits_offset),
    .vrfWriteRequest_bits_mask(vrfWriteRequest_bits_mask),
    .vrfWriteRequest_bits_data(vrfWriteRequest_bits_data),
    .vrfWriteRequest_bits_last(vrfWriteRequest_bits_last),
    .vrfWriteRequest_bits_instructionIndex(vrfWriteRequest_bits_instructionIndex),
    .readRequest_valid(readRequest_valid),
    .readRequest_ready(readRequest_ready),
    .readRequest_bits_vs(readRequest_bits_vs),
    .readRequest_bits_offset(readRequest_bits_offset),
    .readResult_valid(readResult_valid),
    .readResult_data(readResult_data),
    .writeDone_valid(writeDone_valid),
    .writeDone_bits_instructionIndex(writeDone_bits_instructionIndex),
    .instructionActive(instructionActive)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setWrite(input logic v, input logic [4:0] vd, input logic [1:0] off,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic last, input logic [2:0] idx);
    vrfWriteRequest_valid                 = v;
    vrfWriteRequest_bits_vd               = vd;
    vrfWriteRequest_bits_offset           = off;
    vrfWriteRequest_bits_mask             = mask;
    vrfWriteRequest_bits_data             = data;
    vrfWriteRequest_bits_last             = last;
    vrfWriteRequest_bits_instructionIndex = idx;
  endtask

  task automatic readWord(input logic [4:0] vs, input logic [1:0] off,
                          input logic [31:0] exp, input string tag);
    readRequest_valid       = 1'b1;
    readRequest_bits_vs     = vs;
    readRequest_bits_offset = off;
    step();
    check({tag, "_valid"}, 32'(readResult_valid), 32'd1);
    check({tag, "_data"}, readResult_data, exp);
    readRequest_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    setWrite(1'b0, 5'd0, 2'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    readRequest_valid       = 1'b0;
    readRequest_bits_vs     = '0;
    readRequest_bits_offset = '0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Post-reset state
    check("rst_wrReady", 32'(vrfWriteRequest_ready), 32'd1);
    check("rst_rdReady", 32'(readRequest_ready), 32'd1);
    check("rst_rdValid", 32'(readResult_valid), 32'd0);
    check("rst_wdValid", 32'(writeDone_valid), 32'd0);
    check("rst_active", 32'(instructionActive), 32'd0);
    readWord(5'd0, 2'd0, 32'h0, "rst_rd0");

    // Full-word write with completion
    setWrite(1'b1, 5'd3, 2'd2, 4'hF, 32'hDEADBEEF, 1'b1, 3'd5);
    check("fw_activePre", 32'(instructionActive), 32'd0);
    step();
    setWrite(1'b0, 5'd0, 2'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    check("fw_activeBuf", 32'(instructionActive), 32'h20);
    check("fw_wdEarly", 32'(writeDone_valid), 32'd0);
    step();
    check("fw_wdValid", 32'(writeDone_valid), 32'd1);
    check("fw_wdIdx", 32'(writeDone_bits_instructionIndex), 32'd5);
    check("fw_activeDone", 32'(instructionActive), 32'd0);
    step();
    check("fw_wdPulse", 32'(writeDone_valid), 32'd0);
    readWord(5'd3, 2'd2, 32'hDEADBEEF, "fw_rd");

    // Partial byte mask
    setWrite(1'b1, 5'd3, 2'd2, 4'b0101, 32'h11223344, 1'b0, 3'd1);
    step();
    setWrite(1'b0, 5'd0, 2'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    step();
    check("pm_noDone", 32'(writeDone_valid), 32'd0);
    readWord(5'd3, 2'd2, 32'hDE22BE44, "pm_rd");

    // Backpressure and starvation under a continuous read stream
    readRequest_valid       = 1'b1;
    readRequest_bits_vs     = 5'd3;
    readRequest_bits_offset = 2'd2;
    setWrite(1'b1, 5'd10, 2'd0, 4'hF, 32'h0A0A0A0A, 1'b1, 3'd2);
    step();
    check("bp_wrReady1", 32'(vrfWriteRequest_ready), 32'd1);
    check("bp_rdReady1", 32'(readRequest_ready), 32'd1);
    setWrite(1'b1, 5'd10, 2'd1, 4'hF, 32'h0B0B0B0B, 1'b1, 3'd3);
    step();
    check("bp_full", 32'(vrfWriteRequest_ready), 32'd0);
    check("bp_active2", 32'(instructionActive), 32'h0C);
    check("bp_rdReady2", 32'(readRequest_ready), 32'd1);
    setWrite(1'b1, 5'd10, 2'd2, 4'hF, 32'h0C0C0C0C, 1'b1, 3'd4);
    step();
    check("bp_full3", 32'(vrfWriteRequest_ready), 32'd0);
    check("bp_rdReady3", 32'(readRequest_ready), 32'd1);
    step();
    check("bp_force1", 32'(readRequest_ready), 32'd0);
    check("bp_fullForce", 32'(vrfWriteRequest_ready), 32'd0);
    check("bp_rdData", readResult_data, 32'hDE22BE44);
    step();
    check("bp_wdA", 32'(writeDone_valid), 32'd1);
    check("bp_wdIdxA", 32'(writeDone_bits_instructionIndex), 32'd2);
    check("bp_noRead", 32'(readResult_valid), 32'd0);
    check("bp_rdReadyBack", 32'(readRequest_ready), 32'd1);
    check("bp_wrReadyBack", 32'(vrfWriteRequest_ready), 32'd1);
    check("bp_activeB", 32'(instructionActive), 32'h08);
    step();
    setWrite(1'b0, 5'd0, 2'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    check("bp_activeBC", 32'(instructionActive), 32'h18);
    check("bp_fullAgain", 32'(vrfWriteRequest_ready), 32'd0);
    check("bp_wdOnce", 32'(writeDone_valid), 32'd0);
    check("bp_readAgain", 32'(readResult_valid), 32'd1);
    step();
    check("bp_rdReady7", 32'(readRequest_ready), 32'd1);
    step();
    check("bp_force2", 32'(readRequest_ready), 32'd0);
    step();
    check("bp_wdB", 32'(writeDone_valid), 32'd1);
    check("bp_wdIdxB", 32'(writeDone_bits_instructionIndex), 32'd3);
    check("bp_activeC", 32'(instructionActive), 32'h10);
    readRequest_valid = 1'b0;
    step();
    check("bp_wdC", 32'(writeDone_valid), 32'd1);
    check("bp_wdIdxC", 32'(writeDone_bits_instructionIndex), 32'd4);
    check("bp_activeEmpty", 32'(instructionActive), 32'd0);
    step();
    readWord(5'd10, 2'd0, 32'h0A0A0A0A, "bp_rdA");
    readWord(5'd10, 2'd1, 32'h0B0B0B0B, "bp_rdB");
    readWord(5'd10, 2'd2, 32'h0C0C0C0C, "bp_rdC");

    // Address extremes
    setWrite(1'b1, 5'd31, 2'd3, 4'hF, 32'hA5A5A5A5, 1'b0, 3'd0);
    step();
    setWrite(1'b0, 5'd0, 2'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    step();
    readWord(5'd0, 2'd0, 32'h0, "ax_rd0");
    readWord(5'd31, 2'd3, 32'hA5A5A5A5, "ax_rd127");

    // Reset mid-operation with two buffered entries
    readRequest_valid       = 1'b1;
    readRequest_bits_vs     = 5'd31;
    readRequest_bits_offset = 2'd3;
    setWrite(1'b1, 5'd5, 2'd1, 4'hF, 32'h12345678, 1'b1, 3'd6);
    step();
    setWrite(1'b1, 5'd6, 2'd0, 4'hF, 32'h87654321, 1'b0, 3'd7);
    step();
    setWrite(1'b0, 5'd0, 2'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    check("mr_activePre", 32'(instructionActive), 32'hC0);
    check("mr_dataPre", readResult_data, 32'hA5A5A5A5);
    #2;
    reset = 1'b0;
    #1;
    check("mr_active", 32'(instructionActive), 32'd0);
    check("mr_wrReady", 32'(vrfWriteRequest_ready), 32'd1);
    check("mr_rdValid", 32'(readResult_valid), 32'd0);
    check("mr_rdData", readResult_data, 32'h0);
    check("mr_wdValid", 32'(writeDone_valid), 32'd0);
    readRequest_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mr_noDone", 32'(writeDone_valid), 32'd0);
      check("mr_noActive", 32'(instructionActive), 32'd0);
    end
    readWord(5'd5, 2'd1, 32'h0, "mr_rdX");
    readWord(5'd6, 2'd0, 32'h0, "mr_rdY");
    readWord(5'd31, 2'd3, 32'h0, "mr_rd127");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/lane_vrf_write_port.md
Name: lane_vrf_write_port

Overview:
- Lane-side receiver of the VRF write-request channel driven by the lane's stage-3 write queue.
- Buffers incoming write requests (vd, offset, byte mask, data, last, instructionIndex) in a small FIFO.
- Commits each request into a single-ported 128 x 32-bit register-file array with byte enables, sharing the array port with a read port.
- Reports per-instruction completion when a write marked last commits.

Parameters:
- BUF_DEPTH, 2, write-buffer entries (power of two, >=2)
- STARVE_LIMIT, 3, consecutive read-won cycles with a pending write before the write is forced

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- vrfWriteRequest_valid  in  1  write request present
- vrfWriteRequest_ready  out  1  request accepted when valid&ready
- vrfWriteRequest_bits_vd  in  5  vector register
- vrfWriteRequest_bits_offset  in  2  32-bit slice within vd
- vrfWriteRequest_bits_mask  in  4  byte enables
- vrfWriteRequest_bits_data  in  32  write data
- vrfWriteRequest_bits_last  in  1  final write of the instruction
- vrfWriteRequest_bits_instructionIndex  in  3  instruction tag
- readRequest_valid  in  1  read request
- readRequest_ready  out  1  read granted this cycle
- readRequest_bits_vs  in  5  vector register to read
- readRequest_bits_offset  in  2  slice to read
- readResult_valid  out  1  read data valid (registered)
- readResult_data  out  32  read data
- writeDone_valid  out  1  one-cycle completion pulse
- writeDone_bits_instructionIndex  out  3  tag of the completed instruction
- instructionActive  out  8  bit i = buffer holds an entry tagged i

Behaviour:
- Reset (reset=0, asynchronous):
  - Buffer empties; stall counter clears; all 128 array words clear to 0.
  - readResult_valid=0, readResult_data=0, writeDone_valid=0, writeDone_bits_instructionIndex=0.
  - vrfWriteRequest_ready=1 and instructionActive=0 (both follow from the empty buffer).
- Word address = {vd, offset}, 7 bits. vd=31, offset=3 maps to word 127. There is no wrap and no aliasing.
- Write acceptance:
  - vrfWriteRequest_ready = ~full. It never depends on valid or on a same-cycle pop.
  - A full buffer with a simultaneous pop still refuses the push.
  - Push on valid&ready. There is no bypass: an entry accepted at edge t commits no earlier than edge t+1.
- Array-port arbitration, evaluated each cycle:
  - force = (stallCount == STARVE_LIMIT) and buffer non-empty.
  - readRequest_ready = ~force.
  - A read is granted when readRequest_valid & readRequest_ready.
  - The write commits when the buffer is non-empty and no read is granted.
  - stallCount increments when the buffer is non-empty and a read is granted. It clears on any commit and when the buffer is empty.
- Commit:
  - Pop the head entry; for each byte i with mask[i]=1, word[8i+7:8i] <= data[8i+7:8i].
  - mask=0 still pops the entry and leaves the array unchanged.
  - If the committed entry has last=1: next cycle writeDone_valid=1 with its instructionIndex. Otherwise writeDone_valid=0 next cycle.
- Read:
  - A granted read registers the array word. readResult_valid=1 and readResult_data are presented the next cycle; otherwise readResult_valid=0 and data holds its last value.
  - Latency is 1 cycle.
  - No forwarding from the buffer: a read returns the array contents, which are stale for addresses still buffered.
- instructionActive is combinational from the valid buffer entries. It includes an entry committing this cycle; that entry's bit clears after the edge.
- FIFO pointers wrap modulo BUF_DEPTH. The occupancy counter distinguishes full from empty.
- Reset mid-operation: buffered entries are discarded and no writeDone is issued for them.

Test Plan:
- Reset, then release:
  - Required: vrfWriteRequest_ready=1, readRequest_ready=1, readResult_valid=0, writeDone_valid=0, instructionActive=0.
  - Required: a read of word 0 returns 0.
- Full-word write with completion:
  - Stimulus: write vd=3 off=2 mask=0xF data=0xDEADBEEF last=1 idx=5, no reads.
  - Required: commit at the next edge; writeDone_valid=1 with idx=5 for one cycle; instructionActive[5]=1 only while buffered.
  - Then read vs=3 off=2. Required: readResult_data=0xDEADBEEF one cycle later.
- Partial mask:
  - Stimulus: starting from 0xDEADBEEF, write mask=0b0101 data=0x11223344.
  - Required: read returns 0xDE22BE44.
- Backpressure and starvation:
  - Stimulus: hold readRequest_valid=1 continuously and offer 3 back-to-back writes.
  - Required: 2 writes are accepted, then vrfWriteRequest_ready=0.
  - Required: after 3 read-granted cycles, readRequest_ready=0 for exactly 1 cycle and one write commits; the pattern repeats.
- Address extremes:
  - Stimulus: write vd=31 off=3 data=0xA5A5A5A5, then read word 0 and vs=31 off=3.
  - Required: word 0 reads 0; vs=31 off=3 reads 0xA5A5A5A5.
- Reset mid-operation:
  - Stimulus: 2 entries buffered (one with last=1) while a read blocks commit; assert reset=0 asynchronously mid-cycle.
  - Required: outputs go to reset values immediately; no writeDone pulse follows; reads of both targets return 0.
